// File: rtl/theremin_pkg.sv
// theremin_pkg: FSM encoding and raster geometry shared by the note-display control path.
package theremin_pkg;

  localparam int GRID_W             = 240;
  localparam int GRID_H             = 180;
  localparam int BOX_DIM            = 60;
  localparam int NUM_BOXES          = 12;
  localparam int PLOT_DELAY_DEFAULT = 3;

  typedef enum logic [3:0] {
    IDLE,
    DEF_DRAW,
    DEF_DRAIN,
    WAIT_BEAT,
    SHIFT,
    BOX_LOAD,
    BOX_DRAW,
    BOX_DRAIN,
    SCORE_SAMPLE,
    SCORE_ADD,
    DONE
  } state_t;

endpackage

// File: rtl/song_draw_control_raster.sv
// raster_counter: column-major W x H scan (y inner), with linear address and a last-pixel flag.
// Latency: outputs are registered; one step per enabled cycle.
// Backpressure: none; holds at (W-1,H-1) until cleared rather than wrapping.
module raster_counter #(
  parameter int W  = 240,
  parameter int H  = 180,
  parameter int XW = 8,
  parameter int YW = 8,
  parameter int AW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [AW-1:0] addr,
  output logic          last
);

  assign last = (x == XW'(W - 1)) && (y == YW'(H - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (enable && !last) begin
      addr <= addr + 1'b1;
      if (y == YW'(H - 1)) begin
        y <= '0;
        x <= x + 1'b1;
      end else begin
        y <= y + 1'b1;
      end
    end
  end

endmodule

// File: rtl/song_draw_control.sv
// song_draw_control: sequences default paint, per-beat note-box repaint and scoring; SONG_PAUSE_EN adds a pause input.
// Latency: strobes are decoded from the state register; plot trails pixel issue by PLOT_DELAY cycles.
// Backpressure: none; the raster free-runs, only pause (when built in) can stall WAIT_BEAT.
module song_draw_control
  import theremin_pkg::*;
#(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int SONG_STEPS  = 112,
  parameter int PLOT_DELAY  = PLOT_DELAY_DEFAULT,
  parameter int DRAW_W      = GRID_W,
  parameter int DRAW_H      = GRID_H,
  parameter int BOX_SIZE    = BOX_DIM
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
`ifdef SONG_PAUSE_EN
  input  logic        pause,
`endif
  output logic        shiftSong,
  output logic        loadStartAddress,
  output logic        loadX,
  output logic        loadY,
  output logic        writeToScreen,
  output logic        loadDefault,
  output logic        writeDefault,
  output logic        changeScore,
  output logic        addScore,
  output logic        songDone,
  output logic [15:0] gridCounter,
  output logic [15:0] memAddressGridCounter,
  output logic [3:0]  boxCounter,
  output logic [14:0] pixelCount,
  output logic [14:0] memAddressPixelCount,
  output logic        plot
);

  localparam int BW = $clog2(BEAT_CYCLES + 1);
  localparam int SW = $clog2(SONG_STEPS + 1);
  localparam int DW = $clog2(PLOT_DELAY + 1);

  state_t                state, nextState;
  logic [BW-1:0]         beatCnt;
  logic [SW-1:0]         stepCnt;
  logic [DW-1:0]         drainCnt;
  logic [3:0]            boxCnt;
  logic [PLOT_DELAY-1:0] plotPipe;
  logic                  gridLast, pixLast, drainDone, beatDone, beatHold, moreBoxes;
  logic                  gridClear, pixClear, plotIssue;
  logic [7:0]            gridX, gridY, pixX;
  logic [6:0]            pixY;

`ifdef SONG_PAUSE_EN
  assign beatHold = pause;
`else
  assign beatHold = 1'b0;
`endif

  assign drainDone = drainCnt == DW'(PLOT_DELAY - 1);
  assign beatDone  = beatCnt == BW'(BEAT_CYCLES - 1);
  assign moreBoxes = boxCnt < 4'(NUM_BOXES);

  // Counters hold through the drain so the final address stays visible; each box restarts at 0 in BOX_LOAD.
  assign gridClear = !(state inside {DEF_DRAW, DEF_DRAIN});
  assign pixClear  = !(state inside {BOX_DRAW, BOX_DRAIN}) || (nextState == BOX_LOAD);

  raster_counter #(.W(DRAW_W), .H(DRAW_H), .XW(8), .YW(8), .AW(16)) gridRaster (
    .clock  (clock),
    .reset  (reset),
    .clear  (gridClear),
    .enable (state == DEF_DRAW),
    .x      (gridX),
    .y      (gridY),
    .addr   (memAddressGridCounter),
    .last   (gridLast)
  );

  raster_counter #(.W(BOX_SIZE), .H(BOX_SIZE), .XW(8), .YW(7), .AW(15)) boxRaster (
    .clock  (clock),
    .reset  (reset),
    .clear  (pixClear),
    .enable (state == BOX_DRAW),
    .x      (pixX),
    .y      (pixY),
    .addr   (memAddressPixelCount),
    .last   (pixLast)
  );

  assign gridCounter = {gridX, gridY};
  assign pixelCount  = {pixX, pixY};
  assign boxCounter  = boxCnt;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState        = state;
    shiftSong        = 1'b0;
    loadStartAddress = 1'b0;
    loadX            = 1'b0;
    loadY            = 1'b0;
    writeToScreen    = 1'b0;
    loadDefault      = 1'b0;
    writeDefault     = 1'b0;
    changeScore      = 1'b0;
    addScore         = 1'b0;
    songDone         = 1'b0;
    case (state)
      IDLE:      if (start) nextState = DEF_DRAW;
      DEF_DRAW: begin
        loadDefault  = 1'b1;
        writeDefault = 1'b1;
        if (gridLast) nextState = DEF_DRAIN;
      end
      DEF_DRAIN: begin
        writeDefault = 1'b1;
        if (drainDone) nextState = WAIT_BEAT;
      end
      WAIT_BEAT: if (!beatHold && beatDone) nextState = SHIFT;
      SHIFT: begin
        shiftSong = 1'b1;
        nextState = BOX_LOAD;
      end
      BOX_LOAD: begin
        loadStartAddress = 1'b1;
        writeToScreen    = 1'b1;
        nextState        = BOX_DRAW;
      end
      BOX_DRAW: begin
        loadX         = 1'b1;
        loadY         = 1'b1;
        writeToScreen = 1'b1;
        if (pixLast) nextState = moreBoxes ? BOX_LOAD : BOX_DRAIN;
      end
      BOX_DRAIN: begin
        writeToScreen = 1'b1;
        if (drainDone) nextState = SCORE_SAMPLE;
      end
      SCORE_SAMPLE: begin
        changeScore = 1'b1;
        nextState   = SCORE_ADD;
      end
      SCORE_ADD: begin
        addScore  = 1'b1;
        nextState = (stepCnt == SW'(SONG_STEPS)) ? DONE : WAIT_BEAT;
      end
      DONE: begin
        songDone  = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign plotIssue = (loadX & loadY) | loadDefault;
  assign plot      = plotPipe[PLOT_DELAY-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      beatCnt  <= '0;
      stepCnt  <= '0;
      drainCnt <= '0;
      boxCnt   <= '0;
      plotPipe <= '0;
    end else begin
      plotPipe <= (plotPipe << 1) | PLOT_DELAY'(plotIssue);

      if (state != WAIT_BEAT)  beatCnt <= '0;
      else if (!beatHold)      beatCnt <= beatDone ? '0 : beatCnt + 1'b1;

      if (state inside {DEF_DRAIN, BOX_DRAIN}) drainCnt <= drainDone ? '0 : drainCnt + 1'b1;
      else                                     drainCnt <= '0;

      if (state == SHIFT)     stepCnt <= stepCnt + 1'b1;
      else if (state == DONE) stepCnt <= '0;

      if (state == SHIFT)                                 boxCnt <= 4'd1;
      else if (state == BOX_DRAW && pixLast && moreBoxes) boxCnt <= boxCnt + 1'b1;
      else if (state == BOX_DRAIN && drainDone)           boxCnt <= '0;
    end
  end

endmodule

// File: tb/tb_song_draw_control.sv
// Directed bench for song_draw_control on a reduced 24x18 grid with 6x6 boxes, 4-cycle beats, 2-step songs.
module tb_song_draw_control;

  localparam int GW = 24, GH = 18, BD = 6, BEATS = 4, STEPS = 2, PD = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b1;
`ifdef SONG_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic        shiftSong, loadStartAddress, loadX, loadY, writeToScreen;
  logic        loadDefault, writeDefault, changeScore, addScore, songDone, plot;
  logic [15:0] gridCounter, memAddressGridCounter;
  logic [3:0]  boxCounter;
  logic [14:0] pixelCount, memAddressPixelCount;

  always #5 clock = ~clock;

  song_draw_control #(
    .BEAT_CYCLES(BEATS), .SONG_STEPS(STEPS), .PLOT_DELAY(PD),
    .DRAW_W(GW), .DRAW_H(GH), .BOX_SIZE(BD)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (start),
`ifdef SONG_PAUSE_EN
    .pause                 (pause),
`endif
    .shiftSong             (shiftSong),
    .loadStartAddress      (loadStartAddress),
    .loadX                 (loadX),
    .loadY                 (loadY),
    .writeToScreen         (writeToScreen),
    .loadDefault           (loadDefault),
    .writeDefault          (writeDefault),
    .changeScore           (changeScore),
    .addScore              (addScore),
    .songDone              (songDone),
    .gridCounter           (gridCounter),
    .memAddressGridCounter (memAddressGridCounter),
    .boxCounter            (boxCounter),
    .pixelCount            (pixelCount),
    .memAddressPixelCount  (memAddressPixelCount),
    .plot                  (plot)
  );

  wire anyOut = |{shiftSong, loadStartAddress, loadX, loadY, writeToScreen, loadDefault,
                  writeDefault, changeScore, addScore, songDone, plot, gridCounter,
                  memAddressGridCounter, boxCounter, pixelCount, memAddressPixelCount};
  wire issue  = (loadX & loadY) | loadDefault;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Observation scoreboard, sampled on the falling edge.
  int cyc = 0, nLoadDef = 0, nPlot = 0, nShift = 0, nChange = 0, nAdd = 0, nDone = 0;
  int plotErr = 0, seqErr = 0, exclErr = 0, rasterErr = 0;
  int nLoadX [0:15];
  int lastEnd = 0, shiftGap = 0;
  int gx = 0, gy = 0, bx = 0, by = 0;
  logic [15:0] lastGrid = '0, lastGridAddr = '0;
  logic [14:0] lastPix = '0, lastPixAddr = '0;
  logic [PD-1:0] hist = '0;
  logic prevLoadStart = 1'b0, prevChange = 1'b0;
  logic [3:0] prevBox = '0;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (plot !== hist[PD-1]) plotErr <= plotErr + 1;
    hist <= reset ? '0 : {hist[PD-2:0], issue};
    if (plot) nPlot <= nPlot + 1;

    if (loadDefault) begin
      nLoadDef     <= nLoadDef + 1;
      lastGrid     <= gridCounter;
      lastGridAddr <= memAddressGridCounter;
      if (gridCounter !== {gx[7:0], gy[7:0]} || memAddressGridCounter !== 16'(gx * GH + gy))
        rasterErr <= rasterErr + 1;
      if (gy == GH - 1) begin gy <= 0; gx <= gx + 1; end
      else gy <= gy + 1;
    end else begin
      gx <= 0; gy <= 0;
    end

    if (loadX) begin
      nLoadX[boxCounter] <= nLoadX[boxCounter] + 1;
      lastPix     <= pixelCount;
      lastPixAddr <= memAddressPixelCount;
      if (pixelCount !== {bx[7:0], by[6:0]} || memAddressPixelCount !== 15'(bx * BD + by))
        rasterErr <= rasterErr + 1;
      if (by == BD - 1) begin by <= 0; bx <= bx + 1; end
      else by <= by + 1;
    end else begin
      bx <= 0; by <= 0;
    end

    if (writeDefault || addScore) lastEnd <= cyc;
    if (shiftSong) begin nShift <= nShift + 1; shiftGap <= cyc - lastEnd; end
    if (changeScore) nChange <= nChange + 1;
    if (addScore) nAdd <= nAdd + 1;
    if (songDone) nDone <= nDone + 1;

    if (boxCounter != prevBox && boxCounter != 4'd0 &&
        (boxCounter != prevBox + 4'd1 || !loadStartAddress)) seqErr <= seqErr + 1;
    if (loadX && pixelCount == 15'd0 && !prevLoadStart) seqErr <= seqErr + 1;
    if (addScore && !prevChange) seqErr <= seqErr + 1;
    if (loadX != loadY || (loadX && !writeToScreen) || (loadDefault && !writeDefault) ||
        $countones({shiftSong, loadStartAddress, loadX, changeScore, addScore, songDone, writeDefault}) > 1)
      exclErr <= exclErr + 1;
    prevBox       <= boxCounter;
    prevLoadStart <= loadStartAddress;
    prevChange    <= changeScore;
  end

  function automatic bit evt(input int which);
    case (which)
      0: return songDone;
      1: return loadX;
      2: return loadX && boxCounter == 4'd12;
      3: return loadX && boxCounter == 4'd7 && memAddressPixelCount == 15'd10;
      4: return shiftSong;
      5: return writeDefault && !loadDefault;
      default: return 1'b0;
    endcase
  endfunction

  task automatic waitEvt(input string tag, input int which, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clock);
      hit = evt(which);
    end
    chk({tag, "_seen"}, 32'(hit), 1);
  endtask

  int n0;

  initial begin
    // Reset with start held high.
    repeat (2) @(negedge clock);
    chk("rst_outs", 32'(anyOut), 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("rel_idle", 32'(anyOut), 0);
    @(negedge clock);
    chk("first_ld", 32'(loadDefault), 1);
    chk("first_grid", 32'(gridCounter), 0);
    @(posedge clock); #1 start = 1'b0;

    // Song 1: start pulses while drawing boxes must be ignored.
    waitEvt("box_draw", 1, 2000);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    waitEvt("box12", 2, 2000);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    waitEvt("done1", 0, 3000);
    @(negedge clock);
    chk("idle_after_done", 32'(anyOut), 0);
    repeat (4) @(negedge clock);
    chk("n_loaddef", 32'(nLoadDef), GW * GH);
    chk("last_grid", 32'(lastGrid), 32'h1711);
    chk("last_grid_addr", 32'(lastGridAddr), GW * GH - 1);
    chk("n_plot", 32'(nPlot), GW * GH + STEPS * 12 * BD * BD);
    chk("n_loadx_box0", 32'(nLoadX[0]), 0);
    chk("n_loadx_box1", 32'(nLoadX[1]), STEPS * BD * BD);
    chk("n_loadx_box7", 32'(nLoadX[7]), STEPS * BD * BD);
    chk("n_loadx_box12", 32'(nLoadX[12]), STEPS * BD * BD);
    chk("n_loadx_box13", 32'(nLoadX[13]), 0);
    chk("last_pix", 32'(lastPix), 32'h285);
    chk("last_pix_addr", 32'(lastPixAddr), BD * BD - 1);
    chk("n_shift", 32'(nShift), STEPS);
    chk("n_change", 32'(nChange), STEPS);
    chk("n_add", 32'(nAdd), STEPS);
    chk("n_done", 32'(nDone), 1);
    chk("shift_gap", 32'(shiftGap), BEATS + 1);

    // Song 2: start held high throughout.
    @(posedge clock); #1 start = 1'b1;
`ifdef SONG_PAUSE_EN
    waitEvt("drain", 5, 2000);
    repeat (3) @(negedge clock);
    @(posedge clock); #1 pause = 1'b1;
    repeat (10) @(posedge clock);
    #1 pause = 1'b0;
    waitEvt("shift2", 4, 200);
    @(negedge clock);
    chk("pause_gap", 32'(shiftGap), BEATS + 1 + 10);
`else
    waitEvt("shift2", 4, 2000);
    @(negedge clock);
    chk("shift_gap2", 32'(shiftGap), BEATS + 1);
`endif
    waitEvt("done2", 0, 3000);
    @(negedge clock);
    chk("restart_idle", 32'(anyOut), 0);
    @(negedge clock);
    chk("restart_ld", 32'(loadDefault), 1);
    chk("restart_grid", 32'(gridCounter), 0);
    @(posedge clock); #1 start = 1'b0;

    // Song 3: reset in the middle of box 7.
    waitEvt("box7", 3, 3000);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("midrst_outs", 32'(anyOut), 0);
    chk("midrst_box", 32'(boxCounter), 0);
    n0 = nPlot;
    @(posedge clock); #1 reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("midrst_no_plot", 32'(nPlot - n0), 0);
    chk("midrst_stay_idle", 32'(anyOut), 0);

    chk("plot_align", 32'(plotErr), 0);
    chk("box_sequence", 32'(seqErr), 0);
    chk("strobe_excl", 32'(exclErr), 0);
    chk("raster_order", 32'(rasterErr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
